// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: chunk geometry, padding constants and the
// padder state encoding.
package sha256_pkg;

  localparam int BYTES_IN_CHUNK          = 64;
  localparam int WORDS_IN_CHUNK          = 16;
  localparam int MANDATORY_PADDING_BYTES = 9;  // 0x80 byte + 64-bit length
  localparam int MAX_DATA_BYTES_FINAL    = BYTES_IN_CHUNK - MANDATORY_PADDING_BYTES;

  localparam logic [7:0]  PAD_BYTE = 8'h80;
  localparam logic [31:0] PAD_WORD = {PAD_BYTE, 24'h00_0000};

  localparam int LEN_HI_WORD = 14;
  localparam int LEN_LO_WORD = 15;

  // One 512-bit chunk; element i is schedule word W[i] (bits [32*i +: 32]).
  typedef logic [WORDS_IN_CHUNK-1:0][31:0] chunk_t;

  // Padder state encoding.
  localparam logic [1:0] PAD_FILL  = 2'd0;
  localparam logic [1:0] PAD_EMIT  = 2'd1;
  localparam logic [1:0] PAD_EXTRA = 2'd2;

endpackage

// File: rtl/sha256_padder_tail_mask.sv
// Final-word shaping: keeps the first nbytes bytes of the word (MSB-first),
// places the 0x80 pad byte right after them and zeroes the rest. A full word
// (nbytes == 4) passes through; the pad byte then goes into the next word.
module sha256_padder_tail_mask
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word
);

  // Byte mask plus pad-byte insertion selected by the valid byte count.
  always_comb begin
    word = data;
    case (nbytes)
      3'd0:    word = {PAD_BYTE, 24'h00_0000};
      3'd1:    word = {data[31:24], PAD_BYTE, 16'h0000};
      3'd2:    word = {data[31:16], PAD_BYTE, 8'h00};
      3'd3:    word = {data[31:8], PAD_BYTE};
      default: word = data;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a stream of 32-bit big-endian words into
// 512-bit chunks and appends the standard padding (0x80, zeros, 64-bit bit
// length), adding an extra chunk when the tail does not fit.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds data/control stable while valid is high
// and ready is low; valid never waits on ready. in_ready is high only in
// FILL; out_valid is high only in EMIT, with out_chunk/out_last held stable
// until accepted.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_CNT_W = 61
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_chunk,
  output logic         out_last,
  output logic [1:0]   dbg_state
);

  logic [1:0]           state_q;
  logic [3:0]           idx_q;
  logic [LEN_CNT_W-1:0] cnt_q;
  logic                 pend80_q;
  logic                 need_extra_q;
  logic                 last_flag_q;
  chunk_t               chunk_q;

  logic [LEN_CNT_W-1:0] cnt_sum;
  logic [63:0]          len_sum;
  logic [63:0]          len_cur;
  logic [6:0]           used_bytes;
  logic [31:0]          tail_word;

  sha256_padder_tail_mask u_tail_mask (
    .data   (in_data),
    .nbytes (in_nbytes),
    .word   (tail_word)
  );

  // Byte count including the word being offered, and both bit lengths.
  always_comb begin
    cnt_sum    = cnt_q + LEN_CNT_W'(in_nbytes);
    len_sum    = 64'({cnt_sum, 3'b000});
    len_cur    = 64'({cnt_q, 3'b000});
    used_bytes = {1'b0, idx_q, 2'b00} + 7'(in_nbytes);
  end

  // Padder state machine and chunk buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PAD_FILL;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend80_q     <= 1'b0;
      need_extra_q <= 1'b0;
      last_flag_q  <= 1'b0;
      chunk_q      <= '0;
    end else begin
      case (state_q)
        PAD_FILL: begin
          if (in_valid) begin
            cnt_q <= cnt_sum;
            if (!in_last) begin
              chunk_q[idx_q] <= in_data;
              idx_q          <= idx_q + 4'd1;
              if (idx_q == 4'd15) begin
                state_q     <= PAD_EMIT;
                last_flag_q <= 1'b0;
              end
            end else begin
              for (int i = 0; i < WORDS_IN_CHUNK; i++) begin
                if (i > int'(idx_q)) chunk_q[i] <= '0;
              end
              chunk_q[idx_q] <= tail_word;
              // A full last word pushes the pad byte into the next word.
              if (in_nbytes == 3'd4 && idx_q != 4'd15)
                chunk_q[idx_q + 4'd1] <= PAD_WORD;
              if (used_bytes <= 7'(MAX_DATA_BYTES_FINAL)) begin
                chunk_q[LEN_HI_WORD] <= len_sum[63:32];
                chunk_q[LEN_LO_WORD] <= len_sum[31:0];
                last_flag_q          <= 1'b1;
                need_extra_q         <= 1'b0;
              end else begin
                last_flag_q  <= 1'b0;
                need_extra_q <= 1'b1;
                // Only a completely full chunk leaves no room for 0x80.
                pend80_q     <= (used_bytes == 7'(BYTES_IN_CHUNK));
              end
              state_q <= PAD_EMIT;
            end
          end
        end

        PAD_EMIT: begin
          if (out_ready) begin
            if (need_extra_q) begin
              state_q <= PAD_EXTRA;
            end else begin
              state_q     <= PAD_FILL;
              idx_q       <= '0;
              chunk_q     <= '0;
              last_flag_q <= 1'b0;
              if (last_flag_q) begin
                cnt_q    <= '0;
                pend80_q <= 1'b0;
              end
            end
          end
        end

        PAD_EXTRA: begin
          chunk_q              <= '0;
          chunk_q[0]           <= pend80_q ? PAD_WORD : 32'h0000_0000;
          chunk_q[LEN_HI_WORD] <= len_cur[63:32];
          chunk_q[LEN_LO_WORD] <= len_cur[31:0];
          need_extra_q         <= 1'b0;
          last_flag_q          <= 1'b1;
          state_q              <= PAD_EMIT;
        end

        default: state_q <= PAD_FILL;
      endcase
    end
  end

  // Handshake and data outputs decoded straight from registered state.
  always_comb begin
    in_ready  = (state_q == PAD_FILL);
    out_valid = (state_q == PAD_EMIT);
    out_chunk = chunk_q;
    out_last  = last_flag_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: hand-computed chunks for the standard
// padding corner lengths, back-pressure hold and mid-message reset.
module tb_sha256_padder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_chunk;
  logic         out_last;
  logic [1:0]   dbg_state;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] exp_w [16];

  sha256_padder #(.LEN_CNT_W(61)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_nbytes (in_nbytes),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chunk (out_chunk),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Message byte k has value k, packed big-endian four per word.
  function automatic logic [31:0] pat(input int j);
    logic [7:0] b;
    b = 8'(4 * j);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
  endtask

  task automatic push_exp(input logic last);
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_w[i]);
    exp_last_q.push_back(last);
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last);
    int waited;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = data;
    in_nbytes = nb;
    in_last   = last;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nbytes);
    int nw;
    int rem;
    if (nbytes == 0) begin
      send_word(32'h0, 3'd0, 1'b1);
    end else begin
      nw = (nbytes + 3) / 4;
      for (int j = 0; j < nw; j++) begin
        rem = nbytes - 4 * j;
        send_word(pat(j), 3'(rem > 4 ? 4 : rem), (j == nw - 1));
      end
    end
  endtask

  // Waits for a chunk, compares it against the next queued expectation,
  // then completes the handshake.
  task automatic expect_chunk(input string tag);
    int waited;
    logic [31:0] e;
    logic el;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_W%0d", tag, i), 64'(out_chunk[i*32 +: 32]), 64'(e));
    end
    el = exp_last_q.pop_front();
    check({tag, "_last"}, 64'(out_last), 64'(el));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_state",     64'(dbg_state), 64'd0);

    // Empty message.
    clear_exp();
    exp_w[0] = 32'h8000_0000;
    push_exp(1'b1);
    send_msg(0);
    expect_chunk("empty");

    // "abc", with presentation the cycle after the last word.
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    push_exp(1'b1);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    check("abc_latency", 64'(out_valid), 64'd1);
    expect_chunk("abc");

    // 55 bytes: the trailing junk byte 0x37 must be replaced by 0x80.
    clear_exp();
    for (int j = 0; j < 13; j++) exp_w[j] = pat(j);
    exp_w[13] = 32'h3435_3680;
    exp_w[15] = 32'h0000_01B8;
    push_exp(1'b1);
    send_msg(55);
    expect_chunk("b55");

    // 56 bytes: two chunks, with back-pressure on the first.
    clear_exp();
    for (int j = 0; j < 14; j++) exp_w[j] = pat(j);
    exp_w[14] = 32'h8000_0000;
    push_exp(1'b0);
    clear_exp();
    exp_w[15] = 32'h0000_01C0;
    push_exp(1'b1);
    send_msg(56);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready),  64'd0);
      check("bp_last",     64'(out_last),  64'd0);
      check("bp_W14",      64'(out_chunk[14*32 +: 32]), 64'h8000_0000);
    end
    expect_chunk("b56_c1");
    expect_chunk("b56_c2");

    // 64 bytes: data-only chunk, then the extra chunk two cycles later.
    clear_exp();
    for (int j = 0; j < 16; j++) exp_w[j] = pat(j);
    push_exp(1'b0);
    clear_exp();
    exp_w[0]  = 32'h8000_0000;
    exp_w[15] = 32'h0000_0200;
    push_exp(1'b1);
    send_msg(64);
    expect_chunk("b64_c1");
    check("extra_gap_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("extra_lat_valid", 64'(out_valid), 64'd1);
    expect_chunk("b64_c2");
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Reset while a full chunk is being presented mid-message.
    for (int j = 0; j < 16; j++) send_word(pat(j), 3'd4, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    push_exp(1'b1);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    expect_chunk("abc_after_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
